baud_rate_controller: RTL and testbench
=======================================

# baud_rate_controller

Runtime-configurable baud timing controller for the CNC UART link. It owns the divisor, produces the 16x oversample `tick` for the UART receiver and a 1x `bit_tick` for the transmitter, and accepts divisor changes from the host-command logic through a valid/ready handshake. A change is applied only when the UART reports idle, so no frame is corrupted mid-bit. Replaces the fixed-limit tick generator wherever the baud rate must change without reconfiguring the FPGA.

## Interface
- `DIV_W`, 16, divisor/counter width
- `DEFAULT_DIV`, 325, divisor after reset (50 MHz / (9600 x 16))
- `MIN_DIV`, 2, smallest legal divisor; smaller requests are rejected
- `clk_50MHz`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  level; 1 = generate ticks, 0 = halt and clear counters
- `cfg_div`  in  DIV_W  requested divisor, sampled on handshake
- `cfg_valid`  in  1  request valid; hold until accepted
- `cfg_ready`  out  1  controller can accept a request
- `cfg_err`  out  1  one-cycle pulse: last accepted request was rejected
- `uart_busy`  in  1  OR of TX/RX frame-active flags
- `tick`  out  1  one-cycle pulse every `div_active` cycles
- `bit_tick`  out  1  one-cycle pulse on every 16th `tick`
- `div_active`  out  DIV_W  divisor currently in use
- `state`  out  2  FSM state: OFF=00, RUN=01, PEND=10, LOAD=11

## Operation
- Registers: `cnt` (DIV_W bits), `sub` (4 bits), `div_active`, `div_pend`, FSM state, and the `cfg_err` flop.
- Reset values: state=OFF, `cnt`=0, `sub`=0, `div_active`=`DEFAULT_DIV`, `div_pend`=`DEFAULT_DIV`, `cfg_err`=0. This gives `tick`=0, `bit_tick`=0, `cfg_ready`=1.
- `tick` = (state==RUN or PEND) and `cnt`==`div_active`-1. Decoded from registers, no extra latency.
- `bit_tick` = `tick` and `sub`==15.
- `cfg_ready` = 1 in OFF and RUN, 0 in PEND and LOAD.
- Handshake occurs when `cfg_valid`&&`cfg_ready`.
- Rejected request (`cfg_div` < `MIN_DIV`):
  - `cfg_err`=1 on the next cycle only.
  - No register or state change.
- Counting in RUN/PEND:
  - `cnt` increments each cycle and wraps to 0 when `cnt`==`div_active`-1.
  - On that wrap `sub` increments modulo 16.
- OFF:
  - `cnt` and `sub` are held at 0.
  - A legal request writes `div_active` directly at the next edge; state stays OFF.
  - `enable`=1 -> RUN.
- RUN:
  - A legal request writes `div_pend` -> PEND.
  - `enable`=0 -> OFF; clear `cnt` and `sub`.
- PEND:
  - Counting continues with the old divisor.
  - `uart_busy`=0 -> LOAD.
  - `enable`=0 -> OFF and `div_active`<=`div_pend`, so the request is not lost.
- LOAD (one cycle):
  - `div_active`<=`div_pend`, `cnt`<=0, `sub`<=0, no tick.
  - -> RUN, or -> OFF if `enable`=0.
- Priority: `enable`=0 overrides every other transition. In RUN, if `enable`=0 and a handshake occur in the same cycle, the request is still written to `div_active`, and the state goes to OFF.
- `cnt` compare uses the full DIV_W width. `div_active` is never below `MIN_DIV`, so `div_active`-1 cannot underflow.

## Timing
- After entering RUN (with `cnt`=0), the first `tick` occurs in the `div_active`-th RUN cycle, then every `div_active` cycles.
- First `bit_tick` occurs at tick 16, i.e. 16x`div_active` cycles after entering RUN.
- Request latency, with handshake in cycle N and `uart_busy`=0:
  - N+1: PEND.
  - N+2: LOAD.
  - N+3: RUN with new `div_active`, `cnt`=0.
  - First new-rate tick at cycle N+2+`div_new`.
- A `tick` falling in cycle N+1 (PEND) still uses the old divisor. No tick in LOAD.
- If `uart_busy` stays 1, PEND holds indefinitely and old-rate ticks continue.
- `cfg_err` appears in cycle N+1 after a rejected handshake in cycle N.
- Reset asserted in any state: all registers return to reset values at the next edge, and any pending request is discarded.

## Test plan
- Reset, `enable`=1, with `DEFAULT_DIV`=4 -> first `tick` in 4th RUN cycle, then every 4 cycles; `bit_tick` on every 16th tick (every 64 cycles); `div_active`=4.
- In RUN with `uart_busy`=0, `cfg_div`=6 handshake at N -> state PEND at N+1, LOAD at N+2, `div_active`=6 from N+3, next tick at N+8, then every 6.
- `uart_busy`=1 while a request for 10 is pending, held for 50 cycles -> `cfg_ready`=0 throughout, ticks continue at period 4; after `uart_busy` falls, LOAD follows, then period 10.
- `cfg_div`=1 handshake -> `cfg_err`=1 for exactly one cycle; `div_active`, state and tick period unchanged.
- `enable`=0 during PEND with `div_pend`=8 -> OFF next cycle, `div_active`=8, no ticks; `enable`=1 -> first tick 8 cycles after entering RUN.
- `reset` pulsed during PEND -> state OFF, `div_active`=`DEFAULT_DIV`, `tick`/`bit_tick`/`cfg_err`=0, `cfg_ready`=1.

Source files
------------

// File: rtl/baud_rate_controller.sv
// baud_rate_controller
// Runtime-configurable baud timing: owns the divisor, emits a 16x oversample
// tick and a 1x bit tick, and swaps the divisor only while the UART is idle.
module baud_rate_controller #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 325,
  parameter int MIN_DIV     = 2
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             uart_busy,
  output logic             tick,
  output logic             bit_tick,
  output logic [DIV_W-1:0] div_active,
  output logic [1:0]       state
);

  localparam logic [1:0] S_OFF  = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_PEND = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  localparam logic [DIV_W-1:0] LP_DEFAULT = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] LP_MIN     = DIV_W'(MIN_DIV);

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [3:0]       r_sub;
  logic [DIV_W-1:0] r_div_active;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_cfg_err;

  logic w_counting;
  logic w_tick;
  logic w_ready;
  logic w_handshake;
  logic w_accept;

  // Outputs decode straight from registers so the tick has no extra latency.
  // div_active never drops below MIN_DIV, so the subtraction cannot wrap.
  assign w_counting  = (r_state == S_RUN) || (r_state == S_PEND);
  assign w_tick      = w_counting && (r_cnt == r_div_active - DIV_W'(1));
  assign w_ready     = (r_state == S_OFF) || (r_state == S_RUN);
  assign w_handshake = cfg_valid && w_ready;
  assign w_accept    = w_handshake && (cfg_div >= LP_MIN);

  assign tick       = w_tick;
  assign bit_tick   = w_tick && (r_sub == 4'd15);
  assign cfg_ready  = w_ready;
  assign cfg_err    = r_cfg_err;
  assign div_active = r_div_active;
  assign state      = r_state;

  // Divisor counter and 16-tick subcounter; cleared whenever not counting
  // or when counting is about to stop.
  always_ff @(posedge clk_50MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || !w_counting || !enable) begin
      r_cnt <= '0;
      r_sub <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_sub <= r_sub + 4'd1;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  // Control FSM: divisor handshake, deferred load while the UART is busy,
  // and the one-cycle rejection flag.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state      <= S_OFF;
      r_div_active <= LP_DEFAULT;
      r_div_pend   <= LP_DEFAULT;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= w_handshake && !w_accept;
      case (r_state)
        S_OFF: begin
          if (w_accept) r_div_active <= cfg_div;
          if (enable)   r_state      <= S_RUN;
        end
        S_RUN: begin
          if (!enable) begin
            // A request arriving together with disable is applied directly.
            if (w_accept) r_div_active <= cfg_div;
            r_state <= S_OFF;
          end else if (w_accept) begin
            r_div_pend <= cfg_div;
            r_state    <= S_PEND;
          end
        end
        S_PEND: begin
          if (!enable) begin
            // Keep the pending request rather than dropping it.
            r_div_active <= r_div_pend;
            r_state      <= S_OFF;
          end else if (!uart_busy) begin
            r_state <= S_LOAD;
          end
        end
        default: begin
          r_div_active <= r_div_pend;
          r_state      <= enable ? S_RUN : S_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_rate_controller.sv
// Self-checking bench for baud_rate_controller. The reference model tracks
// the observable mode and derives ticks from elapsed time since the counting
// segment began, using plain modular arithmetic.
module tb_baud_rate_controller;

  localparam int DW  = 16;
  localparam int DEF = 4;
  localparam int MIN = 2;

  logic          clk_50MHz = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] cfg_div;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic          uart_busy;
  logic          tick;
  logic          bit_tick;
  logic [DW-1:0] div_active;
  logic [1:0]    state;

  always #5 clk_50MHz = ~clk_50MHz;

  baud_rate_controller #(.DIV_W(DW), .DEFAULT_DIV(DEF), .MIN_DIV(MIN)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .enable    (enable),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .uart_busy (uart_busy),
    .tick      (tick),
    .bit_tick  (bit_tick),
    .div_active(div_active),
    .state     (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0=OFF 1=RUN 2=PEND 3=LOAD; m_seg is the cycle in which the
  // current counting segment started at count zero.
  int cyc    = 0;
  int m_mode = 0;
  int m_div  = DEF;
  int m_pend = DEF;
  int m_seg  = 0;
  int m_err  = 0;
  int dut_ticks = 0, exp_ticks = 0, dut_bits = 0, exp_bits = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_tick();
    int e;
    if (m_mode != 1 && m_mode != 2) return 0;
    e = cyc - m_seg;
    return (e % m_div == m_div - 1) ? 1 : 0;
  endfunction

  function automatic int model_bit_tick();
    if (model_tick() == 0) return 0;
    return (((cyc - m_seg) / m_div) % 16 == 15) ? 1 : 0;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit en, input int d, input bit v, input bit b);
    int n_mode, n_div, n_pend, n_seg, n_err;
    bit hs, ok;
    reset = r; enable = en; cfg_div = DW'(d); cfg_valid = v; uart_busy = b;
    hs = v && (m_mode == 0 || m_mode == 1);
    ok = hs && (d >= MIN);
    n_mode = m_mode; n_div = m_div; n_pend = m_pend; n_seg = m_seg;
    n_err = (hs && !ok) ? 1 : 0;
    if (r) begin
      n_mode = 0; n_div = DEF; n_pend = DEF; n_err = 0;
    end else begin
      case (m_mode)
        0: begin
          if (ok) n_div = d;
          if (en) begin n_mode = 1; n_seg = cyc + 1; end
        end
        1: begin
          if (!en) begin n_mode = 0; if (ok) n_div = d; end
          else if (ok) begin n_pend = d; n_mode = 2; end
        end
        2: begin
          if (!en) begin n_mode = 0; n_div = m_pend; end
          else if (!b) n_mode = 3;
        end
        default: begin
          n_div = m_pend;
          if (en) begin n_mode = 1; n_seg = cyc + 1; end
          else n_mode = 0;
        end
      endcase
    end
    @(posedge clk_50MHz);
    #1;
    cyc++;
    m_mode = n_mode; m_div = n_div; m_pend = n_pend; m_seg = n_seg; m_err = n_err;
    check("state", int'(state), m_mode);
    check("cfg_ready", int'(cfg_ready), (m_mode < 2) ? 1 : 0);
    check("cfg_err", int'(cfg_err), m_err);
    check("div_active", int'(div_active), m_div);
    check("tick", int'(tick), model_tick());
    check("bit_tick", int'(bit_tick), model_bit_tick());
    dut_ticks += int'(tick);  exp_ticks += model_tick();
    dut_bits  += int'(bit_tick); exp_bits += model_bit_tick();
  endtask

  initial begin
    bit en_r = 1'b1;
    bit busy_r = 1'b0;
    int rate;
    // Reset, then free-run at the default divisor long enough for bit ticks.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 140; i++) step(0, 1, 0, 0, 0);
    // Idle-UART divisor change to 6.
    step(0, 1, 6, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0);
    // Request 10 while the UART stays busy, then release.
    step(0, 1, 10, 1, 1);
    for (int i = 0; i < 50; i++) step(0, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0);
    // Illegal divisor is rejected.
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    // Disable while a request for 8 is pending, then re-enable.
    step(0, 1, 8, 1, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0);
    // Disable coinciding with a handshake in RUN; legal request in OFF.
    step(0, 0, 3, 1, 0);
    step(0, 0, 7, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    // Reset pulse while pending.
    step(0, 1, 5, 1, 1);
    step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    // Randomized traffic: sparse requests first (so bit ticks occur), then dense.
    for (int i = 0; i < 4000; i++) begin
      rate = (i < 1500) ? 400 : 25;
      if ($urandom_range(0, 149) == 0) en_r = ~en_r;
      if ($urandom_range(0, 9) == 0) busy_r = ~busy_r;
      step(($urandom_range(0, 499) == 0), en_r, int'($urandom_range(0, 12)),
           ($urandom_range(0, rate - 1) == 0), busy_r);
    end
    check("tick_count", dut_ticks, exp_ticks);
    check("bit_tick_count", dut_bits, exp_bits);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
